instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/mips_pkg.sv | 38 +++
 rtl/instr_encode.sv | 37 +++
 rtl/instr_loader.sv | 136 +++++++++++++
 tb/tb_instr_loader.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, loader descriptor kinds and loader FSM states.
// Control decode imports the same opcode constants.
package mips_pkg;

    typedef enum logic [3:0] {
        K_RTYPE = 4'd0,
        K_LW    = 4'd1,
        K_SW    = 4'd2,
        K_BEQ   = 4'd3,
        K_ADDI  = 4'd4,
        K_ANDI  = 4'd5,
        K_ORI   = 4'd6,
        K_SLTI  = 4'd7,
        K_J     = 4'd8,
        K_JAL   = 4'd9,
        K_LUI   = 4'd10
    } kind_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_WRITE  = 2'd2,
        ST_FINISH = 2'd3
    } loader_state_e;

endpackage

// File: rtl/instr_encode.sv
// Packs a descriptor (kind + fields) into a 32-bit MIPS instruction word.
// Kinds 11-15 produce a zero word and raise o_illegal.
module instr_encode
    import mips_pkg::*;
(
    input  logic [3:0]  i_kind,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_shamt,
    input  logic [5:0]  i_funct,
    input  logic [15:0] i_imm,
    input  logic [25:0] i_target,
    output logic [31:0] o_word,
    output logic        o_illegal
);

    always_comb begin
        o_word    = '0;
        o_illegal = 1'b0;
        case (i_kind)
            K_RTYPE: o_word = {OP_RTYPE, i_rs, i_rt, i_rd, i_shamt, i_funct};
            K_LW:    o_word = {OP_LW,   i_rs, i_rt, i_imm};
            K_SW:    o_word = {OP_SW,   i_rs, i_rt, i_imm};
            K_BEQ:   o_word = {OP_BEQ,  i_rs, i_rt, i_imm};
            K_ADDI:  o_word = {OP_ADDI, i_rs, i_rt, i_imm};
            K_ANDI:  o_word = {OP_ANDI, i_rs, i_rt, i_imm};
            K_ORI:   o_word = {OP_ORI,  i_rs, i_rt, i_imm};
            K_SLTI:  o_word = {OP_SLTI, i_rs, i_rt, i_imm};
            K_LUI:   o_word = {OP_LUI,  5'd0, i_rt, i_imm};
            K_J:     o_word = {OP_J,    i_target};
            K_JAL:   o_word = {OP_JAL,  i_target};
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_loader.sv
// Accepts instruction descriptors, encodes them and writes one word per descriptor
// into instruction memory at consecutive addresses starting from base_addr.
//   state     | meaning
//   ST_IDLE   | waiting for start
//   ST_ACCEPT | in_ready high, waiting for a descriptor
//   ST_WRITE  | one-cycle memory write of the registered word
//   ST_FINISH | one-cycle done pulse
module instr_loader
    import mips_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_kind,
    input  logic [4:0]    in_rs,
    input  logic [4:0]    in_rt,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_shamt,
    input  logic [5:0]    in_funct,
    input  logic [15:0]   in_imm,
    input  logic [25:0]   in_target,
    input  logic          in_last,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          full,
    output logic [AW:0]   count
);

    loader_state_e r_state;
    loader_state_e w_next;

    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_waddr;
    logic [31:0]   r_wdata;
    logic          r_last;
    logic          r_err;
    logic          r_full;
    logic [AW:0]   r_count;

    logic [31:0]   w_word;
    logic          w_illegal;
    logic          w_ready;
    logic          w_hs;
    logic          w_at_top;

    instr_encode u_encode (
        .i_kind    (in_kind),
        .i_rs      (in_rs),
        .i_rt      (in_rt),
        .i_rd      (in_rd),
        .i_shamt   (in_shamt),
        .i_funct   (in_funct),
        .i_imm     (in_imm),
        .i_target  (in_target),
        .o_word    (w_word),
        .o_illegal (w_illegal)
    );

    assign w_hs     = in_valid & w_ready;
    assign w_at_top = (r_waddr == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_next = ST_ACCEPT;
            ST_ACCEPT: if (w_hs)  w_next = w_illegal ? ST_FINISH : ST_WRITE;
            ST_WRITE:  w_next = (r_last || w_at_top) ? ST_FINISH : ST_ACCEPT;
            ST_FINISH: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_ready = (r_state == ST_ACCEPT);
        imem_we = (r_state == ST_WRITE);
        busy    = (r_state != ST_IDLE);
        done    = (r_state == ST_FINISH);
    end

    // Write address/data are captured at the handshake so they stay stable
    // through the write and hold afterwards while the next address advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
            r_full  <= 1'b0;
            r_count <= '0;
        end else begin
            if (r_state == ST_IDLE && start) begin
                r_addr  <= base_addr;
                r_err   <= 1'b0;
                r_full  <= 1'b0;
                r_count <= '0;
            end
            if (w_hs) begin
                if (w_illegal) begin
                    r_err <= 1'b1;
                end else begin
                    r_wdata <= w_word;
                    r_waddr <= r_addr;
                    r_last  <= in_last;
                end
            end
            if (r_state == ST_WRITE) begin
                r_addr  <= r_addr + 1'b1;
                r_count <= r_count + 1'b1;
                if (!r_last && w_at_top) r_full <= 1'b1;
            end
        end
    end

    assign in_ready   = w_ready;
    assign imem_addr  = r_waddr;
    assign imem_wdata = r_wdata;
    assign err        = r_err;
    assign full       = r_full;
    assign count      = r_count;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: encodings, session control, top-of-memory stop,
// illegal kinds and asynchronous reset.
module tb_instr_loader;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_kind;
    logic [4:0]    in_rs, in_rt, in_rd, in_shamt;
    logic [5:0]    in_funct;
    logic [15:0]   in_imm;
    logic [25:0]   in_target;
    logic          in_last;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          busy, done, err, full;
    logic [AW:0]   count;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [AW-1:0] wr_addr[$];
    logic [31:0]   wr_data[$];
    int            wr_cyc[$];
    int            n_done = 0;

    instr_loader #(.AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .err(err), .full(full), .count(count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
            wr_cyc.push_back(cyc);
        end
        if (done === 1'b1) n_done++;
    end

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        n_done = 0;
    endtask

    task automatic do_start(input logic [AW-1:0] b);
        @(negedge clk);
        start = 1'b1;
        base_addr = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                        input logic [15:0] imm, input logic [25:0] tg, input logic last,
                        input int budget, output bit accepted);
        @(negedge clk);
        in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
        in_funct = fn; in_imm = imm; in_target = tg; in_last = last;
        in_valid = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (in_ready === 1'b1) begin
                accepted = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (accepted) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_checks++;
        if ({in_ready, imem_we, busy, done, err, full} !== 6'b0) begin
            n_errors++;
            $display("FAIL reset_flags got=%b want=000000", {in_ready, imem_we, busy, done, err, full});
        end
        n_checks++;
        if (count !== '0) begin
            n_errors++;
            $display("FAIL reset_count got=%0d want=0", count);
        end
        n_checks++;
        if (imem_addr !== '0 || imem_wdata !== '0) begin
            n_errors++;
            $display("FAIL reset_imem got=%h/%h want=00/00000000", imem_addr, imem_wdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_after_reset got busy=%b ready=%b want 0/0", busy, in_ready);
        end
    endtask

    task automatic test_addi();
        bit acc, seen;
        clear_log();
        do_start(8'h00);
        n_checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL addi_accept_state got busy=%b ready=%b want 1/1", busy, in_ready);
        end
        send(4'd4, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd5, 26'd0, 1'b1, 20, acc);
        wait_done(seen);
        n_checks++;
        if (!acc || !seen) begin
            n_errors++;
            $display("FAIL addi_handshake got acc=%b done=%b want 1/1", acc, seen);
        end
        n_checks++;
        if (count !== 9'd1 || err !== 1'b0 || full !== 1'b0) begin
            n_errors++;
            $display("FAIL addi_status got count=%0d err=%b full=%b want 1/0/0", count, err, full);
        end
        n_checks++;
        if (wr_addr.size() != 1) begin
            n_errors++;
            $display("FAIL addi_nwrites got=%0d want=1", wr_addr.size());
        end else if (wr_addr[0] !== 8'h00 || wr_data[0] !== 32'h20080005) begin
            n_errors++;
            $display("FAIL addi_word got=%h@%h want=20080005@00", wr_data[0], wr_addr[0]);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || n_done != 1) begin
            n_errors++;
            $display("FAIL addi_end got busy=%b ndone=%0d want 0/1", busy, n_done);
        end
    endtask

    task automatic test_back_to_back();
        bit acc1, acc2, seen;
        clear_log();
        do_start(8'h00);
        send(4'd1, 5'd8, 5'd9, 5'd0, 5'd0, 6'd0, 16'd4, 26'd0, 1'b0, 20, acc1);
        send(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'hBEEF, 26'h3FFFFFF, 1'b1, 20, acc2);
        wait_done(seen);
        n_checks++;
        if (!acc1 || !acc2 || !seen || count !== 9'd2) begin
            n_errors++;
            $display("FAIL b2b_session got acc=%b%b done=%b count=%0d want 11/1/2", acc1, acc2, seen, count);
        end
        n_checks++;
        if (wr_addr.size() != 2) begin
            n_errors++;
            $display("FAIL b2b_nwrites got=%0d want=2", wr_addr.size());
        end else begin
            if (wr_addr[0] !== 8'h00 || wr_data[0] !== 32'h8D090004) begin
                n_errors++;
                $display("FAIL b2b_lw got=%h@%h want=8D090004@00", wr_data[0], wr_addr[0]);
            end
            n_checks++;
            if (wr_addr[1] !== 8'h01 || wr_data[1] !== 32'h00221820) begin
                n_errors++;
                $display("FAIL b2b_rtype got=%h@%h want=00221820@01", wr_data[1], wr_addr[1]);
            end
            n_checks++;
            if (wr_cyc[1] - wr_cyc[0] != 2) begin
                n_errors++;
                $display("FAIL b2b_spacing got=%0d want=2", wr_cyc[1] - wr_cyc[0]);
            end
        end
    endtask

    task automatic test_jump();
        bit acc1, acc2, acc3, seen;
        clear_log();
        do_start(8'h40);
        send(4'd8, 5'd7, 5'd3, 5'd9, 5'd1, 6'h3F, 16'hFFFF, 26'h10, 1'b0, 20, acc1);
        send(4'd9, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10, 1'b0, 20, acc2);
        send(4'd10, 5'd5, 5'd1, 5'd2, 5'd3, 6'h11, 16'h1234, 26'h3FFFFFF, 1'b1, 20, acc3);
        wait_done(seen);
        n_checks++;
        if (!(acc1 && acc2 && acc3 && seen) || wr_addr.size() != 3) begin
            n_errors++;
            $display("FAIL jump_session got acc=%b%b%b done=%b nwr=%0d want 111/1/3", acc1, acc2, acc3, seen, wr_addr.size());
        end else begin
            n_checks++;
            if (wr_data[0] !== 32'h08000010 || wr_data[1] !== 32'h0C000010 || wr_data[2] !== 32'h3C011234) begin
                n_errors++;
                $display("FAIL jump_words got=%h %h %h want=08000010 0C000010 3C011234", wr_data[0], wr_data[1], wr_data[2]);
            end
            n_checks++;
            if (wr_addr[0] !== 8'h40 || wr_addr[1] !== 8'h41 || wr_addr[2] !== 8'h42) begin
                n_errors++;
                $display("FAIL jump_addrs got=%h %h %h want=40 41 42", wr_addr[0], wr_addr[1], wr_addr[2]);
            end
        end
    endtask

    task automatic test_itype();
        logic [3:0]  k[5]   = '{4'd2, 4'd3, 4'd5, 4'd6, 4'd7};
        logic [4:0]  rs[5]  = '{5'd29, 5'd1, 5'd3, 5'd5, 5'd7};
        logic [4:0]  rt[5]  = '{5'd31, 5'd2, 5'd4, 5'd6, 5'd8};
        logic [15:0] imm[5] = '{16'hFFFC, 16'h0003, 16'h00FF, 16'hABCD, 16'h8000};
        logic [31:0] ex[5]  = '{32'hAFBFFFFC, 32'h10220003, 32'h306400FF, 32'h34A6ABCD, 32'h28E88000};
        bit acc, seen;
        clear_log();
        do_start(8'h80);
        for (int i = 0; i < 5; i++)
            send(k[i], rs[i], rt[i], 5'd0, 5'd0, 6'd0, imm[i], 26'd0, (i == 4), 20, acc);
        wait_done(seen);
        n_checks++;
        if (!seen || wr_addr.size() != 5 || count !== 9'd5) begin
            n_errors++;
            $display("FAIL itype_session got done=%b nwr=%0d count=%0d want 1/5/5", seen, wr_addr.size(), count);
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (wr_data[i] !== ex[i] || wr_addr[i] !== 8'(8'h80 + i)) begin
                    n_errors++;
                    $display("FAIL itype_word%0d got=%h@%h want=%h@%h", i, wr_data[i], wr_addr[i], ex[i], 8'(8'h80 + i));
                end
            end
        end
    endtask

    task automatic test_full();
        bit acc1, acc2, acc3, seen;
        clear_log();
        do_start(8'hFE);
        send(4'd4, 5'd0, 5'd1, 5'd0, 5'd0, 6'd0, 16'd1, 26'd0, 1'b0, 20, acc1);
        send(4'd4, 5'd0, 5'd2, 5'd0, 5'd0, 6'd0, 16'd2, 26'd0, 1'b0, 20, acc2);
        wait_done(seen);
        n_checks++;
        if (!acc1 || !acc2 || !seen || full !== 1'b1 || count !== 9'd2) begin
            n_errors++;
            $display("FAIL full_status got acc=%b%b done=%b full=%b count=%0d want 11/1/1/2", acc1, acc2, seen, full, count);
        end
        send(4'd4, 5'd0, 5'd3, 5'd0, 5'd0, 6'd0, 16'd3, 26'd0, 1'b0, 6, acc3);
        n_checks++;
        if (acc3) begin
            n_errors++;
            $display("FAIL full_third_consumed got=1 want=0");
        end
        n_checks++;
        if (wr_addr.size() != 2) begin
            n_errors++;
            $display("FAIL full_nwrites got=%0d want=2", wr_addr.size());
        end else if (wr_addr[0] !== 8'hFE || wr_addr[1] !== 8'hFF) begin
            n_errors++;
            $display("FAIL full_addrs got=%h %h want=FE FF", wr_addr[0], wr_addr[1]);
        end
        n_checks++;
        if (imem_addr !== 8'hFF || imem_wdata !== 32'h20020002 || full !== 1'b1) begin
            n_errors++;
            $display("FAIL full_hold got=%h/%h full=%b want=FF/20020002/1", imem_addr, imem_wdata, full);
        end
        clear_log();
        do_start(8'hFF);
        n_checks++;
        if (full !== 1'b0 || count !== '0) begin
            n_errors++;
            $display("FAIL full_cleared got full=%b count=%0d want 0/0", full, count);
        end
        send(4'd4, 5'd0, 5'd4, 5'd0, 5'd0, 6'd0, 16'd4, 26'd0, 1'b1, 20, acc1);
        wait_done(seen);
        n_checks++;
        if (!seen || full !== 1'b0 || count !== 9'd1 || wr_addr.size() != 1 || imem_addr !== 8'hFF) begin
            n_errors++;
            $display("FAIL top_last got done=%b full=%b count=%0d nwr=%0d addr=%h want 1/0/1/1/FF", seen, full, count, wr_addr.size(), imem_addr);
        end
    endtask

    task automatic test_illegal();
        bit acc1, acc2, seen;
        clear_log();
        do_start(8'h10);
        send(4'd4, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'd7, 26'd0, 1'b0, 20, acc1);
        send(4'd13, 5'd1, 5'd2, 5'd3, 5'd4, 6'd5, 16'd6, 26'd7, 1'b0, 20, acc2);
        wait_done(seen);
        n_checks++;
        if (!acc1 || !acc2 || !seen || err !== 1'b1 || full !== 1'b0) begin
            n_errors++;
            $display("FAIL illegal_status got acc=%b%b done=%b err=%b full=%b want 11/1/1/0", acc1, acc2, seen, err, full);
        end
        n_checks++;
        if (wr_addr.size() != 1 || count !== 9'd1) begin
            n_errors++;
            $display("FAIL illegal_writes got nwr=%0d count=%0d want 1/1", wr_addr.size(), count);
        end else if (wr_data[0] !== 32'h20220007 || wr_addr[0] !== 8'h10) begin
            n_errors++;
            $display("FAIL illegal_first got=%h@%h want=20220007@10", wr_data[0], wr_addr[0]);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL illegal_sticky got err=%b busy=%b want 1/0", err, busy);
        end
        clear_log();
        do_start(8'h30);
        n_checks++;
        if (err !== 1'b0) begin
            n_errors++;
            $display("FAIL illegal_clear got=%b want=0", err);
        end
        do_start(8'h77);
        send(4'd6, 5'd5, 5'd6, 5'd0, 5'd0, 6'd0, 16'hABCD, 26'd0, 1'b1, 20, acc1);
        wait_done(seen);
        @(negedge clk);
        n_checks++;
        if (!seen || wr_addr.size() != 1 || n_done != 1) begin
            n_errors++;
            $display("FAIL restart_session got done=%b nwr=%0d ndone=%0d want 1/1/1", seen, wr_addr.size(), n_done);
        end else if (wr_addr[0] !== 8'h30 || wr_data[0] !== 32'h34A6ABCD) begin
            n_errors++;
            $display("FAIL restart_word got=%h@%h want=34A6ABCD@30", wr_data[0], wr_addr[0]);
        end
    endtask

    task automatic test_reset_mid();
        bit acc;
        clear_log();
        do_start(8'h20);
        send(4'd4, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd5, 26'd0, 1'b1, 20, acc);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (!acc || {in_ready, imem_we, busy, done, err, full} !== 6'b0 || count !== '0
            || imem_addr !== '0 || imem_wdata !== '0) begin
            n_errors++;
            $display("FAIL midreset_outputs got acc=%b flags=%b count=%0d imem=%h/%h want 1/000000/0/00/00000000",
                     acc, {in_ready, imem_we, busy, done, err, full}, count, imem_addr, imem_wdata);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if (wr_addr.size() != 0 || n_done != 0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_abandon got nwr=%0d ndone=%0d busy=%b want 0/0/0", wr_addr.size(), n_done, busy);
        end
    endtask

    initial begin
        start = 1'b0; base_addr = '0; in_valid = 1'b0; in_kind = '0;
        in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0; in_funct = '0;
        in_imm = '0; in_target = '0; in_last = 1'b0;
        test_reset();
        test_addi();
        test_back_to_back();
        test_jump();
        test_itype();
        test_full();
        test_illegal();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
